// File: rtl/add_pd_pulse_detector.sv
// ---------------------------------------------------------------------------
// add_pd_pulse_detector
//
// Photodetector front-end stage. The asynchronous comparator pulse train is
// brought into the MAIN_CLK_i domain by a two-flop synchroniser. A third flop
// provides rising-edge detection. While enabled, the FSM first waits a
// programmable settle time. It then counts pulse events over back-to-back
// windows of programmable length. At the end of each window it publishes the
// count and a threshold decision.
//
// Optional feature macro: ADD_PD_HYST_EN
//   When defined, the CFREG_PD_HYST_i port exists. Once the flag is set, it
//   only clears when the count falls below (threshold - hysteresis). That
//   difference saturates at 0. When undefined, the flag is simply
//   (count >= threshold) at every evaluation.
//
// Ports
//   MAIN_CLK_i              clock, rising edge
//   N_MAIN_RST_i            asynchronous reset, active-low
//   ANA_PD_EN_i             enable level from CONTROL_MODULE (synchronous)
//   ANA_PD_PULSE_i          raw comparator output (asynchronous)
//   CFREG_PD_SETTLE_i       settle cycles after enable, before first window
//   CFREG_PD_WINDOW_i       window length in cycles (0 behaves as 1)
//   CFREG_PD_THRESHOLD_i    detect threshold (count >= threshold sets flag)
//   CFREG_PD_HYST_i         hysteresis (ADD_PD_HYST_EN builds only)
//   ADD_PD_OUT_OUTFLAG_o    detection result, updated once per window
//   ADD_PD_STA_OUT_READY_o  one-cycle strobe, coincident with each update
//   ADD_PD_COUNT_o          pulse count of the last completed window
// ---------------------------------------------------------------------------
module add_pd_pulse_detector #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 12,
    parameter int SET_W = 8
) (
    input  logic             MAIN_CLK_i,
    input  logic             N_MAIN_RST_i,
    input  logic             ANA_PD_EN_i,
    input  logic             ANA_PD_PULSE_i,
    input  logic [SET_W-1:0] CFREG_PD_SETTLE_i,
    input  logic [WIN_W-1:0] CFREG_PD_WINDOW_i,
    input  logic [CNT_W-1:0] CFREG_PD_THRESHOLD_i,
`ifdef ADD_PD_HYST_EN
    input  logic [CNT_W-1:0] CFREG_PD_HYST_i,
`endif
    output logic             ADD_PD_OUT_OUTFLAG_o,
    output logic             ADD_PD_STA_OUT_READY_o,
    output logic [CNT_W-1:0] ADD_PD_COUNT_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_EVAL   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;            // [0],[1] synchroniser, [2] edge-detect history
    logic             pulse_evt;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [WIN_W-1:0] win_q, win_d;      // COUNT cycles remaining, including the current one
    logic [WIN_W-1:0] win_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             ready_q, ready_d;
    logic             flag_eval;
`ifdef ADD_PD_HYST_EN
    logic [CNT_W-1:0] hyst_q, hyst_d;
    logic [CNT_W-1:0] clr_level;
`endif

    // ---------------- input synchroniser and edge detect ----------------
    always_ff @(posedge MAIN_CLK_i or negedge N_MAIN_RST_i) begin
        if (!N_MAIN_RST_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ANA_PD_PULSE_i};
        end
    end

    assign pulse_evt = sync_q[1] & ~sync_q[2];

    // ---------------- helpers ----------------
    assign win_eff = (CFREG_PD_WINDOW_i == '0) ? WIN_ONE : CFREG_PD_WINDOW_i;
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);

`ifdef ADD_PD_HYST_EN
    // A set flag holds while the count stays at or above the lowered level.
    assign clr_level = (thr_q > hyst_q) ? (thr_q - hyst_q) : '0;
    assign flag_eval = flag_q ? (cnt_q >= clr_level) : (cnt_q >= thr_q);
`else
    assign flag_eval = (cnt_q >= thr_q);
`endif

    // ---------------- FSM next state / datapath ----------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        thr_d    = thr_q;
        count_d  = count_q;
        flag_d   = flag_q;
        ready_d  = 1'b0;
`ifdef ADD_PD_HYST_EN
        hyst_d   = hyst_q;
`endif

        if (!ANA_PD_EN_i) begin
            // Disable wins from any state; a partial window is thrown away.
            state_d  = ST_IDLE;
            settle_d = '0;
            win_d    = '0;
            cnt_d    = '0;
            thr_d    = '0;
            count_d  = '0;
            flag_d   = 1'b0;
`ifdef ADD_PD_HYST_EN
            hyst_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = CFREG_PD_SETTLE_i;
                end
                ST_SETTLE: begin
                    // Events are ignored here, so the window starts from zero.
                    if (settle_q == '0) begin
                        state_d = ST_COUNT;
                        win_d   = win_eff;
                        thr_d   = CFREG_PD_THRESHOLD_i;
                        cnt_d   = '0;
`ifdef ADD_PD_HYST_EN
                        hyst_d  = CFREG_PD_HYST_i;
`endif
                    end else begin
                        settle_d = settle_q - SET_ONE;
                    end
                end
                ST_COUNT: begin
                    if (pulse_evt) begin
                        cnt_d = cnt_inc;
                    end
                    if (win_q <= WIN_ONE) begin
                        state_d = ST_EVAL;
                    end else begin
                        win_d = win_q - WIN_ONE;
                    end
                end
                ST_EVAL: begin
                    // Publish the finished window; the strobe is registered so
                    // it lines up with the new COUNT/OUTFLAG values.
                    count_d = cnt_q;
                    flag_d  = flag_eval;
                    ready_d = 1'b1;
                    // An event in this cycle belongs to the next window.
                    cnt_d   = pulse_evt ? CNT_ONE : '0;
                    win_d   = win_eff;
                    thr_d   = CFREG_PD_THRESHOLD_i;
`ifdef ADD_PD_HYST_EN
                    hyst_d  = CFREG_PD_HYST_i;
`endif
                    state_d = ST_COUNT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge MAIN_CLK_i or negedge N_MAIN_RST_i) begin
        if (!N_MAIN_RST_i) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            thr_q    <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef ADD_PD_HYST_EN
            hyst_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            thr_q    <= thr_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            ready_q  <= ready_d;
`ifdef ADD_PD_HYST_EN
            hyst_q   <= hyst_d;
`endif
        end
    end

    assign ADD_PD_OUT_OUTFLAG_o   = flag_q;
    assign ADD_PD_STA_OUT_READY_o = ready_q;
    assign ADD_PD_COUNT_o         = count_q;

endmodule

// File: tb/tb_add_pd_pulse_detector.sv
// ---------------------------------------------------------------------------
// tb_add_pd_pulse_detector
//
// Randomised bench for add_pd_pulse_detector. Every clock edge is numbered.
// The bench records the pin and enable values sampled at each edge. The
// reference model derives the window schedule arithmetically from the moment
// enable rose. Event n exists when the pin was sampled high at edge n-2 and
// low at edge n-3. Each window count is the saturated sum of events over that
// window's span of edges.
// ---------------------------------------------------------------------------
module tb_add_pd_pulse_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pin;
    logic [7:0] settle_cfg;
    logic [11:0] window_cfg;
    logic [7:0] thr_cfg;
    logic [7:0] hyst_cfg;
    logic       flag_o;
    logic       ready_o;
    logic [7:0] count_o;

    add_pd_pulse_detector dut (
        .MAIN_CLK_i             (clk),
        .N_MAIN_RST_i           (rst_n),
        .ANA_PD_EN_i            (en),
        .ANA_PD_PULSE_i         (pin),
        .CFREG_PD_SETTLE_i      (settle_cfg),
        .CFREG_PD_WINDOW_i      (window_cfg),
        .CFREG_PD_THRESHOLD_i   (thr_cfg),
`ifdef ADD_PD_HYST_EN
        .CFREG_PD_HYST_i        (hyst_cfg),
`endif
        .ADD_PD_OUT_OUTFLAG_o   (flag_o),
        .ADD_PD_STA_OUT_READY_o (ready_o),
        .ADD_PD_COUNT_o         (count_o)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;              // number of the most recent rising edge
    bit pin_a [0:65535];
    bit en_a  [0:65535];

    // model state
    int cfg_s, cfg_w, cfg_thr, cfg_hyst;
    bit in_run   = 0;
    int c0       = 0;
    int weff     = 1;
    int exp_cnt  = 0;
    bit exp_flag = 0;
    bit exp_rdy  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, k, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int ev(input int n);
        if (n < 3) return 0;
        return (pin_a[n-2] && !pin_a[n-3]) ? 1 : 0;
    endfunction

    // Expected outputs right after edge kk.
    task automatic model_edge(input int kk);
        int j, lo, hi, sum, lvl;
        exp_rdy = 0;
        if (!en_a[kk]) begin
            in_run   = 0;
            exp_cnt  = 0;
            exp_flag = 0;
        end else begin
            if (!in_run) begin
                // IDLE sees enable at kk; settle lasts S+1 cycles; counting edges start after that
                in_run = 1;
                c0     = kk + cfg_s + 2;
                weff   = (cfg_w == 0) ? 1 : cfg_w;
            end
            if (kk >= c0 + weff && ((kk - c0 - weff) % (weff + 1)) == 0) begin
                j   = (kk - c0 - weff) / (weff + 1);
                lo  = (j == 0) ? c0 : c0 + j * (weff + 1) - 1;
                hi  = c0 + j * (weff + 1) + weff - 1;
                sum = 0;
                for (int n = lo; n <= hi; n++) sum += ev(n);
                if (sum > 255) sum = 255;
`ifdef ADD_PD_HYST_EN
                lvl = exp_flag ? ((cfg_thr > cfg_hyst) ? cfg_thr - cfg_hyst : 0) : cfg_thr;
`else
                lvl = cfg_thr;
`endif
                exp_flag = (sum >= lvl);
                exp_cnt  = sum;
                exp_rdy  = 1;
                $display("window edge=%0d j=%0d count=%0d flag=%0d", kk, j, sum, exp_flag);
            end
        end
    endtask

    // One clock: check outputs after the edge, then drive inputs for the next edge.
    task automatic step(input logic en_n, input logic pin_n);
        @(posedge clk);
        k++;
        #1;
        model_edge(k);
        check("ready", {31'd0, ready_o}, {31'd0, exp_rdy});
        check("count", {24'd0, count_o}, exp_cnt);
        check("flag",  {31'd0, flag_o},  {31'd0, exp_flag});
        en  = en_n;
        pin = pin_n;
        en_a[k+1]  = en_n;
        pin_a[k+1] = pin_n;
    endtask

    task automatic set_cfg(input int s, input int w, input int thr, input int hyst);
        cfg_s = s; cfg_w = w; cfg_thr = thr; cfg_hyst = hyst;
        settle_cfg = 8'(s);
        window_cfg = 12'(w);
        thr_cfg    = 8'(thr);
        hyst_cfg   = 8'(hyst);
    endtask

    // hp = 0: random pin per cycle; otherwise square wave with half-period hp
    task automatic run(input int s, input int w, input int thr, input int hyst,
                       input int en_cyc, input int idle_cyc, input int hp);
        logic p;
        set_cfg(s, w, thr, hyst);
        $display("run settle=%0d window=%0d thr=%0d hyst=%0d en_cycles=%0d hp=%0d",
                 s, w, thr, hyst, en_cyc, hp);
        for (int i = 0; i < en_cyc + idle_cyc; i++) begin
            p = (hp == 0) ? 1'($urandom_range(0, 1)) : 1'((i / hp) % 2);
            step(i < en_cyc, p);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        pin   = 1'b0;
        set_cfg(0, 0, 0, 0);
        en_a[1] = 0;
        pin_a[1] = 0;

        // Reset held with pulses toggling and enable low.
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2));

        run(4,   20,   5, 0,  200, 6, 2);
        run(4,   20,   5, 0,  150, 6, 0);
        run(0,    0,   0, 0,   40, 4, 0);
        run(2, 4095, 200, 0, 4200, 4, 0);
        run(3,   30,   4, 0,   45, 5, 1);
        run(1,   40,  10, 3,  400, 4, 0);
        run(7,   10,   3, 0,   60, 4, 0);
        for (int r = 0; r < 4; r++) begin
            run($urandom_range(0, 6), $urandom_range(0, 25), $urandom_range(0, 8),
                $urandom_range(0, 4), $urandom_range(30, 120), 4, $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of an active run.
        set_cfg(0, 5, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2));
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        en_a[k+1] = 0;
        #1;
        check("arst_ready", {31'd0, ready_o}, 32'd0);
        check("arst_count", {24'd0, count_o}, 32'd0);
        check("arst_flag",  {31'd0, flag_o},  32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2));
        run(2, 6, 1, 0, 40, 4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
